// File: rtl/inverter_pkg.sv
// Shared types and helpers for the inverter datapath and its checker.
// State encoding, default data width and the expected inverter response.
package inverter_pkg;

  localparam int INV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [INV_WIDTH-1:0] inv_expect(
    input logic [INV_WIDTH-1:0] v
  );
    return ~v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/inverter_checker.sv
// Checks out == ~in on sample pairs over a fixed-length run.
// INVERTER_CHECKER_CAPTURE_EN builds first-mismatch capture registers.
module inverter_checker
  import inverter_pkg::*;
#(
  parameter int WIDTH    = INV_WIDTH,
  parameter int CNT_W    = 16,
  parameter int EXPECT_N = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] smp_in,
  input  logic [WIDTH-1:0] smp_out,
  output logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] smp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_in,
  output logic [WIDTH-1:0] fail_out
);

  state_t state_q, state_d;
  logic   accept;
  logic   mismatch;
  logic   take_start;
  logic   last;

  assign accept     = smp_valid && (state_q == RUN);
  assign mismatch   = (smp_in ^ smp_out) != {WIDTH{1'b1}};
  assign take_start = start && (state_q != RUN);
  assign last       = accept
                   && (smp_count == CNT_W'(EXPECT_N - 1));

  // Run sequencing: start opens a run, the final accept closes it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign smp_ready = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == '0);

  sat_counter #(.W(CNT_W)) u_smp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (take_start),
    .inc (accept),
    .q   (smp_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (take_start),
    .inc (accept && mismatch),
    .q   (err_count)
  );

`ifdef INVERTER_CHECKER_CAPTURE_EN
  logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0] fail_in_q, fail_in_d;
  logic [WIDTH-1:0] fail_out_q, fail_out_d;

  // Latch the first mismatch of a run; a zero error count marks "none yet"
  always_comb begin
    fail_idx_d = fail_idx_q;
    fail_in_d  = fail_in_q;
    fail_out_d = fail_out_q;
    if (take_start) begin
      fail_idx_d = '0;
      fail_in_d  = '0;
      fail_out_d = '0;
    end else if (accept && mismatch && (err_count == '0)) begin
      fail_idx_d = smp_count;
      fail_in_d  = smp_in;
      fail_out_d = smp_out;
    end
  end

  // Capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_idx_q <= '0;
      fail_in_q  <= '0;
      fail_out_q <= '0;
    end else begin
      fail_idx_q <= fail_idx_d;
      fail_in_q  <= fail_in_d;
      fail_out_q <= fail_out_d;
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_in  = fail_in_q;
  assign fail_out = fail_out_q;
`else
  assign fail_idx = '0;
  assign fail_in  = '0;
  assign fail_out = '0;
`endif

endmodule
